stg_mo_sq: RTL
==============

Name: stg_mo_sq

Overview:
Parametrised memory-operation pipeline stage with an in-order store queue.
- Stores are accepted at pipeline rate and drained to memory in the background.
- Loads issue immediately on their selected port, with store-to-load forwarding and hazard stalls.
- Sits between the MA stage (address/port selection) and the WB stage. It generalises the fixed 2-port MO stage to NPORTS ports, configurable width and a buffered store path.

Parameters:
- DATA_W, 24, GP data width; a narrow access is one DATA_W word.
- ADDR_W, 48, address / wide-data width; a wide access (is48) covers word addr and addr+1.
- NPORTS, 2, number of memory ports.
- SQ_DEPTH, 4, store-queue entries; must be a power of two, ≥2.
- SB_W, 16, sideband width (pc/opc/tgt bundle) passed through untouched.

Ports:
- iw_clk  in  1  clock
- iw_rst  in  1  reset, asynchronous, active-high
- iw_valid  in  1  instruction present this cycle
- iw_is_load  in  1  load op
- iw_is_store  in  1  store op
- iw_is48  in  1  1 = wide access (ADDR_W bits), 0 = DATA_W bits
- iw_fence  in  1  hold until store queue empty
- iw_port  in  $clog2(NPORTS)  port chosen by MA for this op
- iw_addr  in  ADDR_W  word address
- iw_wdata  in  ADDR_W  store data; upper bits ignored when !is48
- iw_result  in  ADDR_W  non-memory result, passed through
- iw_sb  in  SB_W  sideband
- ow_stall  out  1  upstream must hold inputs
- ow_valid  out  1  registered output valid
- ow_result  out  ADDR_W  load data or passed-through result
- ow_sb  out  SB_W  registered sideband
- ow_sq_empty  out  1  store queue empty
- ow_mem_re  out  NPORTS  per-port read enable
- ow_mem_we  out  NPORTS  per-port write enable
- ow_mem_is48  out  NPORTS  per-port width
- ow_mem_addr  out  NPORTS*ADDR_W  per-port address, packed, port 0 at LSB
- ow_mem_wdata  out  NPORTS*ADDR_W  per-port write data
- iw_mem_rdata  in  NPORTS*ADDR_W  per-port combinational read data
- iw_mem_busy  in  NPORTS  port unavailable this cycle

Behaviour:
- Reset: queue pointers and count = 0; ow_valid = 0; ow_result, ow_sb = 0; ow_sq_empty = 1; all ow_mem_* = 0; ow_stall = 0. Reset mid-drain discards all queued stores; a partially issued wide write is not completed.
- Latency: every accepted op produces ow_valid exactly one cycle later. A stalled cycle produces ow_valid = 0 (bubble).
- Accept condition: iw_valid & !ow_stall.
- Store:
  - Enqueues {addr, wdata, is48}; narrow stores zero the upper ADDR_W-DATA_W bits.
  - No memory access is made in the accepting cycle.
  - ow_result = iw_result.
- Load:
  - Asserts ow_mem_re[iw_port] with addr and is48 that cycle; iw_mem_rdata[iw_port] is captured into ow_result.
  - Narrow loads zero-extend the low DATA_W bits.
  - If iw_mem_busy[iw_port], stall.
- Non-memory op: ow_result = iw_result next cycle.
- Drain FSM:
  - States: IDLE (count==0) and DRAIN (count>0).
  - In DRAIN, the head entry writes on the lowest-indexed port that is not busy and not used by the current accepted load; the entry is popped that cycle.
  - If no port is free, the head is held.
  - DRAIN→IDLE when count goes 1→0 with no enqueue.
- Count rules:
  - Enqueue + pop in the same cycle leaves count unchanged.
  - Pointers wrap modulo SQ_DEPTH.
  - Full: count==SQ_DEPTH.
- ow_stall asserted when iw_valid and any of:
  - store while full and no pop this cycle; a pop while full frees the slot in the same cycle, so no stall;
  - fence with count≠0, or a pop leaving count≠0;
  - load hazard (see Optional Feature);
  - load port busy.
- Overlap: word ranges [addr, addr+is48] of load and queue entry intersect.
- Exact match: addr equal and is48 equal.
- Multiple matching entries: the youngest wins.

Optional Feature:
Macro: STG_MO_SQ_FWD_EN.
- Defined:
  - Load exactly matching a queued store returns that entry's data (youngest match) with no stall. No memory read is issued and the port is left free for drain.
  - Overlap that is not an exact match stalls until the overlapping entries have drained.
- Undefined: any overlap with a queued entry stalls until those entries have drained; forwarding logic is absent.

Test Plan:
- Reset with queue holding 3 entries -> count=0, ow_sq_empty=1, no ow_mem_we after release.
- Store narrow addr 0x10 data 0xABCDEF, next cycle load narrow 0x10 (FWD_EN) -> ow_result=0x000000ABCDEF one cycle after load, ow_mem_re=0.
- Same as previous without FWD_EN -> ow_stall=1 until the store drains, then load reads 0xABCDEF from memory.
- 5 back-to-back stores with iw_mem_busy=all-1, SQ_DEPTH=4 -> 5th stalls; release busy -> stall drops in the same cycle as the first pop; all 5 written in order.
- Wide store 0x20 = 0x123456789ABC, then narrow load 0x21 -> partial overlap stall under both builds; after drain, load returns 0x123456.
- Fence with 2 queued stores, no busy -> ow_stall high for 2 cycles, released when ow_sq_empty=1; ow_valid for the fence 1 cycle later.

Source files
------------

// File: rtl/stg_mo_sq.sv
// Memory-operation stage: in-order store queue drained in the background, loads issued on the selected port.
// Define STG_MO_SQ_FWD_EN to forward exact-match queued stores to loads instead of stalling.
module stg_mo_sq #(
  parameter int DATA_W   = 24,
  parameter int ADDR_W   = 48,
  parameter int NPORTS   = 2,
  parameter int SQ_DEPTH = 4,
  parameter int SB_W     = 16
) (
  input  logic                       iw_clk,
  input  logic                       iw_rst,
  input  logic                       iw_valid,
  input  logic                       iw_is_load,
  input  logic                       iw_is_store,
  input  logic                       iw_is48,
  input  logic                       iw_fence,
  input  logic [$clog2(NPORTS)-1:0]  iw_port,
  input  logic [ADDR_W-1:0]          iw_addr,
  input  logic [ADDR_W-1:0]          iw_wdata,
  input  logic [ADDR_W-1:0]          iw_result,
  input  logic [SB_W-1:0]            iw_sb,
  output logic                       ow_stall,
  output logic                       ow_valid,
  output logic [ADDR_W-1:0]          ow_result,
  output logic [SB_W-1:0]            ow_sb,
  output logic                       ow_sq_empty,
  output logic [NPORTS-1:0]          ow_mem_re,
  output logic [NPORTS-1:0]          ow_mem_we,
  output logic [NPORTS-1:0]          ow_mem_is48,
  output logic [NPORTS*ADDR_W-1:0]   ow_mem_addr,
  output logic [NPORTS*ADDR_W-1:0]   ow_mem_wdata,
  input  logic [NPORTS*ADDR_W-1:0]   iw_mem_rdata,
  input  logic [NPORTS-1:0]          iw_mem_busy
);
  localparam int QW  = $clog2(SQ_DEPTH);
  localparam int CW  = QW + 1;
  localparam int PW  = $clog2(NPORTS);
  localparam int AW1 = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] NARROW_MASK = {{(ADDR_W-DATA_W){1'b0}}, {DATA_W{1'b1}}};

  typedef enum logic {IDLE, DRAIN} state_t;
  state_t state, state_next;

  logic [ADDR_W-1:0] sq_addr [SQ_DEPTH];
  logic [ADDR_W-1:0] sq_data [SQ_DEPTH];
  logic              sq_w    [SQ_DEPTH];
  logic [QW-1:0]     head, tail, idx;
  logic [CW-1:0]     count, count_next;

  logic [AW1-1:0]    ld_lo, ld_hi, e_lo, e_hi;
  logic              any_ovl, hazard, need_mem, port_busy;
  logic              load_stall, fence_stall, store_stall, stall;
  logic              load_use, pop, accept, enq, full;
  logic [PW-1:0]     drain_port;
  logic [ADDR_W-1:0] rdata_sel, ld_result;
`ifdef STG_MO_SQ_FWD_EN
  logic              fwd_ok;
  logic [ADDR_W-1:0] fwd_data;
`endif

  // Scan oldest to youngest so the youngest overlapping entry has the final say.
  always_comb begin
    ld_lo   = {1'b0, iw_addr};
    ld_hi   = ld_lo + AW1'(iw_is48);
    any_ovl = 1'b0;
    idx     = head;
    e_lo    = '0;
    e_hi    = '0;
`ifdef STG_MO_SQ_FWD_EN
    fwd_ok   = 1'b0;
    fwd_data = '0;
`endif
    for (int unsigned i = 0; i < SQ_DEPTH; i++) begin
      idx  = head + QW'(i);
      e_lo = {1'b0, sq_addr[idx]};
      e_hi = e_lo + AW1'(sq_w[idx]);
      if (CW'(i) < count && ld_lo <= e_hi && e_lo <= ld_hi) begin
        any_ovl = 1'b1;
`ifdef STG_MO_SQ_FWD_EN
        if (sq_addr[idx] == iw_addr && sq_w[idx] == iw_is48) begin
          fwd_ok   = 1'b1;
          fwd_data = sq_data[idx];
        end else begin
          fwd_ok = 1'b0;
        end
`endif
      end
    end
`ifdef STG_MO_SQ_FWD_EN
    hazard   = any_ovl & ~fwd_ok;
    need_mem = iw_is_load & ~fwd_ok;
`else
    hazard   = any_ovl;
    need_mem = iw_is_load;
`endif
  end

  always_comb begin
    rdata_sel = '0;
    port_busy = 1'b0;
    for (int unsigned p = 0; p < NPORTS; p++) begin
      if (iw_port == PW'(p)) begin
        rdata_sel = iw_mem_rdata[p*ADDR_W +: ADDR_W];
        port_busy = iw_mem_busy[p];
      end
    end
  end

  // Load port usage is resolved without the store-full term, keeping pop free of a loop through stall.
  assign load_stall  = iw_is_load & (hazard | (need_mem & port_busy));
  assign fence_stall = iw_fence & (count != '0);
  assign load_use    = iw_valid & ~iw_rst & need_mem & ~load_stall & ~fence_stall;
  assign full        = (count == CW'(SQ_DEPTH));
  assign store_stall = iw_is_store & full & ~pop;
  assign stall       = iw_valid & ~iw_rst & (store_stall | fence_stall | load_stall);
  assign accept      = iw_valid & ~iw_rst & ~stall;
  assign enq         = accept & iw_is_store;
  assign ow_stall    = stall;
  assign ow_sq_empty = (count == '0);

  always_comb begin
    pop        = 1'b0;
    drain_port = '0;
    if (state == DRAIN && !iw_rst) begin
      for (int unsigned p = 0; p < NPORTS; p++) begin
        if (!pop && !iw_mem_busy[p] && !(load_use && iw_port == PW'(p))) begin
          pop        = 1'b1;
          drain_port = PW'(p);
        end
      end
    end
    count_next = count + CW'(enq) - CW'(pop);
    state_next = (count_next != '0) ? DRAIN : IDLE;
  end

  always_comb begin
    ow_mem_re    = '0;
    ow_mem_we    = '0;
    ow_mem_is48  = '0;
    ow_mem_addr  = '0;
    ow_mem_wdata = '0;
    for (int unsigned p = 0; p < NPORTS; p++) begin
      if (load_use && iw_port == PW'(p)) begin
        ow_mem_re[p]                     = 1'b1;
        ow_mem_is48[p]                   = iw_is48;
        ow_mem_addr[p*ADDR_W +: ADDR_W]  = iw_addr;
      end
      if (pop && drain_port == PW'(p)) begin
        ow_mem_we[p]                     = 1'b1;
        ow_mem_is48[p]                   = sq_w[head];
        ow_mem_addr[p*ADDR_W +: ADDR_W]  = sq_addr[head];
        ow_mem_wdata[p*ADDR_W +: ADDR_W] = sq_data[head];
      end
    end
  end

  always_comb begin
    ld_result = iw_result;
    if (iw_is_load) begin
`ifdef STG_MO_SQ_FWD_EN
      ld_result = fwd_ok ? fwd_data : rdata_sel;
`else
      ld_result = rdata_sel;
`endif
      if (!iw_is48) ld_result = ld_result & NARROW_MASK;
    end
  end

  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      state <= IDLE;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (enq) tail <= tail + QW'(1);
      if (pop) head <= head + QW'(1);
    end
  end

  always_ff @(posedge iw_clk) begin
    if (enq) begin
      sq_addr[tail] <= iw_addr;
      sq_data[tail] <= iw_is48 ? iw_wdata : (iw_wdata & NARROW_MASK);
      sq_w[tail]    <= iw_is48;
    end
  end

  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      ow_valid  <= 1'b0;
      ow_result <= '0;
      ow_sb     <= '0;
    end else begin
      ow_valid <= accept;
      if (accept) begin
        ow_result <= ld_result;
        ow_sb     <= iw_sb;
      end
    end
  end
endmodule
